// File: rtl/verinject_injection_sequencer.sv
// Scheduled fault-injection sequencer: drives the shared injector state word with a
// bit index for each queued window [T, T+L] and IDLE_STATE everywhere else.
module verinject_injection_sequencer #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CYCLE_W    = 32,
    parameter logic [31:0] IDLE_STATE = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [CYCLE_W-1:0]       push_cycle,
    input  logic [31:0]              push_bit,
    input  logic [7:0]               push_len,
    output logic [31:0]              verinject__injector_state,
    output logic [CYCLE_W-1:0]       cycle_count,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     inject_active,
    output logic                     done_pulse,
    output logic                     late_error
);

    // state    | meaning
    // S_IDLE   | schedule empty
    // S_WAIT   | head queued; drop it if late, arm one cycle before its target
    // S_INJECT | head window in progress; output carries its bit index
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT} state_e;

    localparam int unsigned          AW       = $clog2(DEPTH);
    localparam logic [AW:0]          CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CYCLE_W:0]     EXT_ONE  = (CYCLE_W+1)'(1);

    logic [CYCLE_W-1:0] mem_cycle [DEPTH];
    logic [31:0]        mem_bit   [DEPTH];
    logic [7:0]         mem_len   [DEPTH];

    logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]        cnt_q;
    state_e             state_q, state_d;
    logic [CYCLE_W-1:0] count_q, count_d;
    logic [31:0]        out_q, out_d;
    logic               done_q, done_d, late_q;
    logic               push_fire, pop, late_set;

    logic [CYCLE_W:0]   count_ext, head_t, head_end, next_t;
    logic               head_late, head_arm, head_last, next_abut;

    assign push_ready = (cnt_q < CNT_FULL) && !clear;
    assign push_fire  = push_valid && push_ready;
    assign rd_nxt     = rd_ptr_q + AW'(1);

    // Comparisons run one bit wider so T-1 and T+L never wrap.
    assign count_ext = {1'b0, count_q};
    assign head_t    = {1'b0, mem_cycle[rd_ptr_q]};
    assign head_end  = head_t + {{(CYCLE_W-7){1'b0}}, mem_len[rd_ptr_q]};
    assign next_t    = {1'b0, mem_cycle[rd_nxt]};
    assign head_late = head_t <= count_ext;
    assign head_arm  = head_t == count_ext + EXT_ONE;
    assign head_last = count_ext == head_end;
    assign next_abut = (cnt_q > CNT_ONE) && (next_t == count_ext + EXT_ONE);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        out_d    = IDLE_STATE;
        done_d   = 1'b0;
        pop      = 1'b0;
        late_set = 1'b0;
        if (enable) begin
            count_d = (&count_q) ? count_q : count_q + CYCLE_W'(1);
            unique case (state_q)
                S_IDLE: begin
                    if (cnt_q != '0) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (head_late) begin
                        pop      = 1'b1;
                        late_set = 1'b1;
                        state_d  = (cnt_q > CNT_ONE) ? S_WAIT : S_IDLE;
                    end else if (head_arm) begin
                        state_d = S_INJECT;
                        out_d   = mem_bit[rd_ptr_q];
                        done_d  = (mem_len[rd_ptr_q] == 8'd0);
                    end
                end
                S_INJECT: begin
                    if (head_last) begin
                        pop = 1'b1;
                        if (next_abut) begin
                            out_d  = mem_bit[rd_nxt];
                            done_d = (mem_len[rd_nxt] == 8'd0);
                        end else begin
                            state_d = (cnt_q > CNT_ONE) ? S_WAIT : S_IDLE;
                        end
                    end else begin
                        out_d  = mem_bit[rd_ptr_q];
                        done_d = (count_ext + EXT_ONE == head_end);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_cycle[wr_ptr_q] <= push_cycle;
            mem_bit[wr_ptr_q]   <= push_bit;
            mem_len[wr_ptr_q]   <= push_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            out_q    <= IDLE_STATE;
            done_q   <= 1'b0;
            late_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            out_q    <= IDLE_STATE;
            done_q   <= 1'b0;
            late_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            out_q   <= out_d;
            done_q  <= done_d;
            if (late_set) late_q <= 1'b1;
            if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_nxt;
            if (push_fire && !pop) cnt_q <= cnt_q + CNT_ONE;
            else if (!push_fire && pop) cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign verinject__injector_state = out_q;
    assign cycle_count               = count_q;
    assign pending                   = cnt_q;
    assign inject_active             = (out_q != IDLE_STATE);
    assign done_pulse                = done_q;
    assign late_error                = late_q;

endmodule

// File: tb/tb_verinject_injection_sequencer.sv
// Directed bench for the injection sequencer; each cycle's output is checked against
// a table of hand-written windows indexed by a bench-tracked cycle count.
module tb_verinject_injection_sequencer;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_cycle = '0;
    logic [31:0] push_bit = '0;
    logic [7:0]  push_len = '0;
    logic [31:0] inj_state;
    logic [31:0] cycle_count;
    logic [3:0]  pending;
    logic        inject_active, done_pulse, late_error;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int act_cnt = 0;
    int nwin = 0;
    int wt [16];
    int wl [16];
    logic [31:0] wb [16];

    verinject_injection_sequencer #(.DEPTH(8), .CYCLE_W(32), .IDLE_STATE(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_cycle(push_cycle), .push_bit(push_bit), .push_len(push_len),
        .verinject__injector_state(inj_state), .cycle_count(cycle_count),
        .pending(pending), .inject_active(inject_active),
        .done_pulse(done_pulse), .late_error(late_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_win(input int t, input int l, input logic [31:0] b);
        wt[nwin] = t;
        wl[nwin] = l;
        wb[nwin] = b;
        nwin++;
    endtask

    function automatic logic [31:0] exp_state(input int c);
        for (int i = 0; i < nwin; i++)
            if (c >= wt[i] && c <= wt[i] + wl[i]) return wb[i];
        return IDLE;
    endfunction

    function automatic logic exp_done(input int c);
        for (int i = 0; i < nwin; i++)
            if (c == wt[i] + wl[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_push(input int t, input logic [31:0] b, input int l);
        push_valid = 1'b1;
        push_cycle = 32'(t);
        push_bit   = b;
        push_len   = 8'(l);
    endtask

    task automatic step();
        logic        en, cl, live;
        logic [31:0] es;
        en = enable;
        cl = clear;
        @(posedge clk);
        #1;
        if (cl) begin
            exp_cnt = 0;
            nwin = 0;
        end else if (en) begin
            exp_cnt++;
        end
        live = en && !cl;
        es = live ? exp_state(exp_cnt) : IDLE;
        chk("cycle_count", cycle_count, 32'(exp_cnt));
        chk("state", inj_state, es);
        chk("done_pulse", 32'(done_pulse), 32'(live && exp_done(exp_cnt)));
        chk("inject_active", 32'(inject_active), 32'(es != IDLE));
        chk("pending_max", 32'(pending <= 4'd8), 32'd1);
        if (inject_active) act_cnt++;
    endtask

    task automatic run_to(input int target);
        int budget;
        budget = 300;
        while (exp_cnt != target && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL run_to_timeout: observed count %0d expected %0d", exp_cnt, target);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", inj_state, IDLE);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_active", 32'(inject_active), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_late", 32'(late_error), 32'd0);
        chk("rst_ready", 32'(push_ready), 32'd1);
        rst_n = 1'b1;

        // Single window T=10 B=5 L=0, pushed at count 0
        enable = 1'b1;
        add_win(10, 0, 32'd5);
        set_push(10, 32'd5, 0);
        step();
        push_valid = 1'b0;
        chk("t1_pending", 32'(pending), 32'd1);
        run_to(15);
        chk("t1_pending_end", 32'(pending), 32'd0);

        // Abutting windows (20,3,3) then (24,7,0)
        add_win(20, 3, 32'd3);
        add_win(24, 0, 32'd7);
        set_push(20, 32'd3, 3);
        step();
        set_push(24, 32'd7, 0);
        step();
        push_valid = 1'b0;
        run_to(28);
        chk("t2_pending_end", 32'(pending), 32'd0);

        // DEPTH+1 back-to-back pushes, T = 40 + 3i
        run_to(30);
        nwin = 0;
        for (int i = 0; i < 9; i++) add_win(40 + 3 * i, 0, 32'(i + 8));
        for (int i = 0; i < 8; i++) begin
            set_push(40 + 3 * i, 32'(i + 8), 0);
            step();
        end
        chk("t3_pending_full", 32'(pending), 32'd8);
        chk("t3_ready_full", 32'(push_ready), 32'd0);
        set_push(64, 32'd16, 0);
        step();
        chk("t3_pending_39", 32'(pending), 32'd8);
        chk("t3_ready_39", 32'(push_ready), 32'd0);
        step();
        step();
        chk("t3_pending_41", 32'(pending), 32'd7);
        chk("t3_ready_41", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
        chk("t3_pending_42", 32'(pending), 32'd8);
        run_to(70);
        chk("t3_pending_end", 32'(pending), 32'd0);

        // Late entry after clear: T=5 pushed at count 12, then valid (20,11,1)
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_clear_pending", 32'(pending), 32'd0);
        chk("t4_clear_late", 32'(late_error), 32'd0);
        run_to(12);
        set_push(5, 32'd9, 0);
        step();
        add_win(20, 1, 32'd11);
        set_push(20, 32'd11, 1);
        step();
        push_valid = 1'b0;
        run_to(16);
        chk("t4_late_set", 32'(late_error), 32'd1);
        chk("t4_pending_16", 32'(pending), 32'd1);
        run_to(25);
        chk("t4_late_sticky", 32'(late_error), 32'd1);
        chk("t4_pending_end", 32'(pending), 32'd0);

        // enable low for 4 cycles inside window T=30 L=5
        nwin = 0;
        add_win(30, 5, 32'd13);
        act_cnt = 0;
        set_push(30, 32'd13, 5);
        step();
        push_valid = 1'b0;
        run_to(32);
        enable = 1'b0;
        repeat (4) step();
        enable = 1'b1;
        run_to(36);
        chk("t5_active_cycles", 32'(act_cnt), 32'd6);

        // clear at count 41 inside window T=40 L=10
        add_win(40, 10, 32'd17);
        set_push(40, 32'd17, 10);
        step();
        push_valid = 1'b0;
        run_to(41);
        chk("t6_state_41", inj_state, 32'd17);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_pending", 32'(pending), 32'd0);
        run_to(5);

        // Asynchronous reset inside window T=10 L=5
        add_win(10, 5, 32'd19);
        set_push(10, 32'd19, 5);
        step();
        push_valid = 1'b0;
        run_to(12);
        chk("t7_state_pre", inj_state, 32'd19);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_state", inj_state, IDLE);
        chk("t7_rst_count", cycle_count, 32'd0);
        chk("t7_rst_active", 32'(inject_active), 32'd0);
        chk("t7_rst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
